pwm_interleaved: RTL and testbench

N-phase interleaved PWM generator for multiphase DC-DC stages, the successor to the single-phase PWM generator. It takes a duty command from the MPPT/control loop and drives NUM_PHASES complementary high/low gate pairs. Each phase's carrier is offset by PERIOD/NUM_PHASES, and every phase has its own dead-time insertion. Duty updates go through shadow registers, soft-start is a power-of-two ramp, and shutdown latches a fault that must be cleared explicitly.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_deadtime.sv | 53 +++++
 rtl/pwm_interleaved.sv | 170 +++++++++++++++++
 tb/tb_pwm_interleaved.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings and default clamp limits for the interleaved PWM generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOFT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } pwm_state_t;

  typedef enum logic [1:0] {
    DT_OFF  = 2'd0,
    DT_DEAD = 2'd1,
    DT_ON   = 2'd2
  } dt_state_t;

  // 90 % of full scale, used when duty_max is 0.
  function automatic int unsigned default_duty_max(input int unsigned duty_bits);
    return (9 * (32'd1 << duty_bits)) / 10;
  endfunction

  // 5 % of full scale, used when duty_min is 0.
  function automatic int unsigned default_duty_min(input int unsigned duty_bits);
    return (32'd1 << duty_bits) / 20;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-phase dead-time insertion: any raw edge blanks both gates for dt_eff cycles
// before the side matching raw is driven; a further edge restarts the blanking.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw,
  input  logic [DT_BITS-1:0] dt_eff,
  input  logic               force_off,
  output logic               gate_h,
  output logic               gate_l
);

  dt_state_t          state;
  logic               raw_q;
  logic [DT_BITS-1:0] dt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DT_OFF;
      raw_q  <= 1'b0;
      dt_cnt <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else begin
      raw_q <= raw;
      if (force_off) begin
        state  <= DT_OFF;
        dt_cnt <= '0;
        gate_h <= 1'b0;
        gate_l <= 1'b0;
      end else if (state == DT_OFF || raw != raw_q) begin
        // Coming out of OFF is treated like an edge so start-up also gets a dead window.
        state  <= DT_DEAD;
        dt_cnt <= dt_eff;
        gate_h <= 1'b0;
        gate_l <= 1'b0;
      end else if (state == DT_DEAD) begin
        if (dt_cnt <= DT_BITS'(1)) begin
          state  <= DT_ON;
          gate_h <= raw;
          gate_l <= ~raw;
        end else begin
          dt_cnt <= dt_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_interleaved.sv
// N-phase interleaved PWM with shadowed duty, clamping, power-of-two soft-start
// and a latched shutdown fault; phase k's carrier leads phase 0 by k*PERIOD/N.
module pwm_interleaved
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PWM_FREQ   = 100_000,
  parameter int NUM_PHASES = 2,
  parameter int DUTY_BITS  = 10,
  parameter int DT_BITS    = 8,
  parameter int SS_SHIFT   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  shutdown,
  input  logic                  fault_clear,
  input  logic [DUTY_BITS-1:0]  duty_cmd,
  input  logic                  duty_load,
  input  logic [DUTY_BITS-1:0]  duty_max,
  input  logic [DUTY_BITS-1:0]  duty_min,
  input  logic [DT_BITS-1:0]    dead_time,
  input  logic                  soft_start_en,
  output logic [NUM_PHASES-1:0] pwm_high,
  output logic [NUM_PHASES-1:0] pwm_low,
  output logic [DUTY_BITS-1:0]  duty_active,
  output logic                  period_start,
  output logic                  fault_latched,
  output logic [1:0]            state_o
);

  localparam int PERIOD  = CLK_FREQ / PWM_FREQ;
  localparam int CNT_W   = $clog2(PERIOD);
  localparam int PH_STEP = PERIOD / NUM_PHASES;
  localparam int PROD_W  = DUTY_BITS + CNT_W + 1;
  localparam int SS_W    = SS_SHIFT + 1;
  localparam int RAMP_W  = DUTY_BITS + SS_W;
  localparam logic [DUTY_BITS-1:0] DEF_MAX = DUTY_BITS'(default_duty_max(DUTY_BITS));
  localparam logic [DUTY_BITS-1:0] DEF_MIN = DUTY_BITS'(default_duty_min(DUTY_BITS));
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(PERIOD - 1);
  localparam logic [SS_W-1:0]      SS_END  = SS_W'(2 ** SS_SHIFT);

  pwm_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [DUTY_BITS-1:0] duty_pend;
  logic [SS_W-1:0]      ss_cnt;
  logic [DT_BITS-1:0]   dt_reg;

  logic [DUTY_BITS-1:0] lim_max, lim_min, lim_lo, duty_clamped;
  logic [SS_W-1:0]      ss_next;
  logic [RAMP_W-1:0]    ramp_prod;
  logic [DUTY_BITS-1:0] ramp_duty;
  logic [PROD_W-1:0]    thr_prod;
  logic [CNT_W:0]       thr;
  logic [DT_BITS-1:0]   dt_eff;
  logic                 running, boundary, force_off;

  // When min exceeds max the upper limit wins.
  always_comb begin
    lim_max = (duty_max == '0) ? DEF_MAX : duty_max;
    lim_min = (duty_min == '0) ? DEF_MIN : duty_min;
    lim_lo  = (lim_min > lim_max) ? lim_max : lim_min;
    if (duty_pend > lim_max)     duty_clamped = lim_max;
    else if (duty_pend < lim_lo) duty_clamped = lim_lo;
    else                         duty_clamped = duty_pend;
  end

  assign ss_next   = ss_cnt + 1'b1;
  assign ramp_prod = RAMP_W'(duty_clamped) * RAMP_W'(ss_next);
  assign ramp_duty = DUTY_BITS'(ramp_prod >> SS_SHIFT);
  assign thr_prod  = PROD_W'(duty_active) * PROD_W'(PERIOD);
  assign thr       = (CNT_W + 1)'(thr_prod >> DUTY_BITS);
  assign dt_eff    = (dt_reg == '0) ? DT_BITS'(1) : dt_reg;

  assign running      = (state == ST_SOFT) || (state == ST_RUN);
  assign boundary     = running && (cnt == LAST);
  // Gates drop the cycle after shutdown or enable-low, ahead of the state change.
  assign force_off    = shutdown || !enable || !running;
  assign period_start = running && (cnt == '0);
  assign state_o      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      duty_pend     <= '0;
      duty_active   <= '0;
      ss_cnt        <= '0;
      dt_reg        <= '0;
      fault_latched <= 1'b0;
    end else begin
      if (duty_load) duty_pend <= duty_cmd;
      if (shutdown) begin
        state         <= ST_FAULT;
        fault_latched <= 1'b1;
        cnt           <= '0;
        duty_active   <= '0;
        ss_cnt        <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable && !fault_latched) begin
              dt_reg <= dead_time;
              cnt    <= '0;
              ss_cnt <= '0;
              if (soft_start_en) begin
                state       <= ST_SOFT;
                duty_active <= '0;
              end else begin
                state       <= ST_RUN;
                duty_active <= duty_clamped;
              end
            end
          end
          ST_SOFT, ST_RUN: begin
            if (!enable) begin
              state       <= ST_IDLE;
              cnt         <= '0;
              ss_cnt      <= '0;
              duty_active <= '0;
            end else begin
              cnt <= boundary ? '0 : cnt + 1'b1;
              if (boundary) begin
                dt_reg <= dead_time;
                if (state == ST_RUN) begin
                  duty_active <= duty_clamped;
                end else if (ss_next == SS_END) begin
                  state       <= ST_RUN;
                  ss_cnt      <= '0;
                  duty_active <= duty_clamped;
                end else begin
                  ss_cnt      <= ss_next;
                  duty_active <= ramp_duty;
                end
              end
            end
          end
          ST_FAULT: begin
            if (fault_clear) begin
              state         <= ST_IDLE;
              fault_latched <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
    localparam int OFFSET = k * PH_STEP;
    logic [CNT_W:0] sum, carrier;
    logic           raw;

    assign sum     = {1'b0, cnt} + (CNT_W + 1)'(OFFSET);
    assign carrier = (sum >= (CNT_W + 1)'(PERIOD)) ? sum - (CNT_W + 1)'(PERIOD) : sum;
    assign raw     = carrier < thr;

    pwm_deadtime #(.DT_BITS(DT_BITS)) u_dt (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw),
      .dt_eff    (dt_eff),
      .force_off (force_off),
      .gate_h    (pwm_high[k]),
      .gate_l    (pwm_low[k])
    );
  end

endmodule

// File: tb/tb_pwm_interleaved.sv
// Bench for pwm_interleaved: a cycle-level integer reference model checked every
// clock, plus table-driven clamp vectors and hand-written multi-cycle scenarios.
module tb_pwm_interleaved;

  localparam int PERIOD = 500;
  localparam int NPH    = 2;
  localparam int DB     = 10;
  localparam int DTB    = 8;
  localparam int SSS    = 2;
  localparam int FULL   = 1 << DB;

  logic           clk, rst_n, enable, shutdown, fault_clear, duty_load, soft_start_en;
  logic [DB-1:0]  duty_cmd, duty_max, duty_min, duty_active;
  logic [DTB-1:0] dead_time;
  logic [NPH-1:0] pwm_high, pwm_low;
  logic           period_start, fault_latched;
  logic [1:0]     state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state number, counter, duties, soft-start step, dead time,
  // and per phase the length of the current run of active cycles with raw high/low.
  int m_state, m_cnt, m_pend, m_duty, m_ss, m_fault, m_dt;
  int run_h[NPH];
  int run_l[NPH];

  typedef struct {
    int cmd;
    int mx;
    int mn;
    int exp_duty;
    int exp_thr;
  } clamp_vec_t;

  clamp_vec_t vecs[6];
  int ss_exp[5] = '{0, 128, 256, 384, 512};

  pwm_interleaved #(
    .CLK_FREQ(50_000_000), .PWM_FREQ(100_000), .NUM_PHASES(NPH),
    .DUTY_BITS(DB), .DT_BITS(DTB), .SS_SHIFT(SSS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .shutdown(shutdown),
    .fault_clear(fault_clear), .duty_cmd(duty_cmd), .duty_load(duty_load),
    .duty_max(duty_max), .duty_min(duty_min), .dead_time(dead_time),
    .soft_start_en(soft_start_en), .pwm_high(pwm_high), .pwm_low(pwm_low),
    .duty_active(duty_active), .period_start(period_start),
    .fault_latched(fault_latched), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic int clamp_model(input int d, input int mx, input int mn);
    int hi, lo;
    hi = (mx == 0) ? (9 * FULL) / 10 : mx;
    lo = (mn == 0) ? FULL / 20 : mn;
    if (lo > hi) lo = hi;
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pend = 0; m_duty = 0; m_ss = 0; m_fault = 0; m_dt = 0;
    for (int k = 0; k < NPH; k++) begin
      run_h[k] = 0;
      run_l[k] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  thr, car, cl;
    bit  act;
    thr = m_duty * PERIOD / FULL;
    act = (m_state == 1 || m_state == 2) && !shutdown && enable;
    for (int k = 0; k < NPH; k++) begin
      car = (m_cnt + k * (PERIOD / NPH)) % PERIOD;
      if (!act) begin
        run_h[k] = 0; run_l[k] = 0;
      end else if (car < thr) begin
        run_h[k]++; run_l[k] = 0;
      end else begin
        run_l[k]++; run_h[k] = 0;
      end
    end
    cl = clamp_model(m_pend, int'(duty_max), int'(duty_min));
    if (shutdown) begin
      m_state = 3; m_fault = 1; m_cnt = 0; m_duty = 0; m_ss = 0;
    end else if (m_state == 0) begin
      if (enable && !m_fault) begin
        m_dt = int'(dead_time); m_cnt = 0; m_ss = 0;
        if (soft_start_en) begin m_state = 1; m_duty = 0; end
        else begin m_state = 2; m_duty = cl; end
      end
    end else if (m_state == 3) begin
      if (fault_clear) begin m_state = 0; m_fault = 0; end
    end else if (!enable) begin
      m_state = 0; m_cnt = 0; m_ss = 0; m_duty = 0;
    end else if (m_cnt == PERIOD - 1) begin
      m_cnt = 0;
      m_dt  = int'(dead_time);
      if (m_state == 2) m_duty = cl;
      else begin
        m_ss++;
        if (m_ss == (1 << SSS)) begin m_state = 2; m_ss = 0; m_duty = cl; end
        else m_duty = cl * m_ss / (1 << SSS);
      end
    end else begin
      m_cnt++;
    end
    if (duty_load) m_pend = int'(duty_cmd);
  endtask

  task automatic check_outputs();
    int dte, eh, el;
    dte = (m_dt == 0) ? 1 : m_dt;
    eh = 0; el = 0;
    for (int k = 0; k < NPH; k++) begin
      if (run_h[k] >= dte + 1) eh |= (1 << k);
      if (run_l[k] >= dte + 1) el |= (1 << k);
    end
    check("pwm_high", int'(pwm_high), eh);
    check("pwm_low", int'(pwm_low), el);
    check("no_overlap", int'(pwm_high & pwm_low), 0);
    check("duty_active", int'(duty_active), m_duty);
    check("state_o", int'(state_o), m_state);
    check("fault_latched", int'(fault_latched), m_fault);
    check("period_start", int'(period_start), ((m_state == 1 || m_state == 2) && m_cnt == 0) ? 1 : 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_cnt(input int target);
    int guard;
    guard = 0;
    while (!(m_cnt == target && (m_state == 1 || m_state == 2))) begin
      if (guard >= 2 * PERIOD) begin
        timeout_fail("wait_cnt");
        break;
      end
      tick();
      guard++;
    end
  endtask

  // Called with the counter at 0; observes one full period of phase 0/1 gates.
  task automatic measure_period(output int hi, output int lo, output int r0, output int r1);
    logic p0, p1;
    hi = 0; lo = 0; r0 = -1; r1 = -1;
    p0 = pwm_high[0]; p1 = pwm_high[1];
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_high[0]) hi++;
      if (pwm_low[0]) lo++;
      if (pwm_high[0] && !p0 && r0 < 0) r0 = i;
      if (pwm_high[1] && !p1 && r1 < 0) r1 = i;
      p0 = pwm_high[0]; p1 = pwm_high[1];
      tick();
    end
  endtask

  task automatic load_duty(input int d);
    duty_cmd  = DB'(d);
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int hi, lo, r0, r1;

    vecs[0] = '{1000, 0,   0,   921, 449};
    vecs[1] = '{10,   0,   0,   51,  24};
    vecs[2] = '{600,  500, 0,   500, 244};
    vecs[3] = '{20,   0,   100, 100, 48};
    vecs[4] = '{300,  200, 400, 200, 97};
    vecs[5] = '{700,  0,   0,   700, 341};

    rst_n = 1'b0; enable = 1'b0; shutdown = 1'b0; fault_clear = 1'b0;
    duty_load = 1'b0; soft_start_en = 1'b0; duty_cmd = '0; duty_max = '0;
    duty_min = '0; dead_time = 8'd10;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of RUN.
    load_duty(512);
    enable = 1'b1;
    repeat (700) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pwm_high", int'(pwm_high), 0);
    check("rst_pwm_low", int'(pwm_low), 0);
    check("rst_duty_active", int'(duty_active), 0);
    check("rst_fault_latched", int'(fault_latched), 0);
    check("rst_state", int'(state_o), 0);
    model_reset();
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 50 % duty, dead time 10: thr = 250.
    load_duty(512);
    enable = 1'b1;
    repeat (PERIOD + 20) tick();
    wait_cnt(0);
    measure_period(hi, lo, r0, r1);
    check("dc512_high_cycles", hi, 240);
    check("dc512_low_cycles", lo, 240);
    check("dc512_rise0", r0, 11);
    check("dc512_phase_offset", r1 - r0, 250);

    // Clamp table.
    foreach (vecs[i]) begin
      duty_max = DB'(vecs[i].mx);
      duty_min = DB'(vecs[i].mn);
      load_duty(vecs[i].cmd);
      wait_cnt(1); wait_cnt(0); wait_cnt(1); wait_cnt(0);
      check($sformatf("clamp%0d_duty", i), int'(duty_active), vecs[i].exp_duty);
      measure_period(hi, lo, r0, r1);
      check($sformatf("clamp%0d_high", i), hi, vecs[i].exp_thr - 10);
      check($sformatf("clamp%0d_low", i), lo, 490 - vecs[i].exp_thr);
    end
    duty_max = '0;
    duty_min = '0;

    // Shadow load mid-period only takes effect after the next wrap.
    wait_cnt(100);
    load_duty(300);
    wait_cnt(PERIOD - 1);
    check("shadow_hold_old", int'(duty_active), 700);
    tick();
    check("shadow_new", int'(duty_active), 300);

    // Shutdown at cnt = 50, clear ignored while shutdown still high.
    wait_cnt(50);
    shutdown = 1'b1;
    tick();
    check("sd_high_off", int'(pwm_high), 0);
    check("sd_low_off", int'(pwm_low), 0);
    check("sd_fault", int'(fault_latched), 1);
    check("sd_state", int'(state_o), 3);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("sd_clear_ignored", int'(state_o), 3);
    shutdown = 1'b0;
    tick();
    check("sd_still_fault", int'(state_o), 3);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("sd_cleared_idle", int'(state_o), 0);
    check("sd_cleared_flag", int'(fault_latched), 0);
    tick();
    check("sd_restart_run", int'(state_o), 2);

    // Soft-start ramp with SS_SHIFT = 2.
    enable = 1'b0;
    repeat (3) tick();
    check("ss_idle", int'(state_o), 0);
    soft_start_en = 1'b1;
    load_duty(512);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wait_cnt(0);
      check($sformatf("ss_duty%0d", i), int'(duty_active), ss_exp[i]);
      check($sformatf("ss_state%0d", i), int'(state_o), (i < 4) ? 1 : 2);
      tick();
    end

    // Randomised segments against the model.
    for (int seg = 0; seg < 6; seg++) begin
      enable = 1'b0; shutdown = 1'b0;
      repeat (3) tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      dead_time     = DTB'($urandom_range(0, 20));
      soft_start_en = 1'($urandom_range(0, 1));
      duty_max      = ($urandom_range(0, 2) == 0) ? DB'($urandom_range(1, 1023)) : '0;
      duty_min      = ($urandom_range(0, 2) == 0) ? DB'($urandom_range(1, 600)) : '0;
      load_duty($urandom_range(0, 1023));
      enable = 1'b1;
      repeat (2500) begin
        duty_load = ($urandom_range(0, 49) == 0);
        if (duty_load) duty_cmd = DB'($urandom_range(0, 1023));
        if ($urandom_range(0, 299) == 0) duty_max = DB'($urandom_range(0, 1023));
        if ($urandom_range(0, 299) == 0) duty_min = DB'($urandom_range(0, 300));
        if ($urandom_range(0, 1499) == 0) begin
          shutdown = 1'b1;
          repeat (3) tick();
          shutdown = 1'b0;
          fault_clear = 1'b1;
          tick();
          fault_clear = 1'b0;
        end
        if ($urandom_range(0, 1999) == 0) begin
          enable = 1'b0;
          repeat (2) tick();
          enable = 1'b1;
        end
        tick();
      end
      duty_load = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
